bsg_credit_rr_arb: RTL and testbench
====================================

# bsg_credit_rr_arb

Credit-gated round-robin arbiter that shares one credit-flow-controlled channel among `els_p` requesters. It sits in the read/sender clock domain next to the async credit counter. It consumes that counter's credits-available signal and returns one credit-decrement pulse per word sent. Multi-word packets can lock the grant until the final word has been sent. A saturating counter records cycles lost to credit starvation.

## Interface
- `els_p`, default 4: number of requesters; legal range 2..16.
- `lg_els_lp`, default `$clog2(els_p)`: width of the tag output; local, not overridable.
- `stall_width_p`, default 16: width of the credit-stall counter.

Ports:
- `clk_i`  in  1  — the single clock.
- `reset_i`  in  1  — synchronous, active-high reset.
- `v_i`  in  els_p  — per-requester word valid.
- `last_i`  in  els_p  — per-requester "this word ends the packet".
- `yumi_o`  out  els_p  — one-hot; the word from that requester is consumed this cycle.
- `credit_avail_i`  in  1  — at least one credit available; driven by the credit counter's `r_credits_avail_o`.
- `dec_credit_o`  out  1  — consume one credit; drives the counter's `r_dec_credit_i`.
- `ready_i`  in  1  — downstream can accept a word.
- `v_o`  out  1  — a word is presented downstream.
- `last_o`  out  1  — the presented word ends its packet.
- `tag_o`  out  lg_els_lp  — index of the granted requester.
- `stall_clear_i`  in  1  — synchronously zero the stall counter.
- `stall_cnt_o`  out  stall_width_p  — count of credit-starved cycles.

## Operation
- **State:** FSM `{ARB, LOCKED}`, owner register (lg_els_lp bits), priority pointer `ptr_r` (lg_els_lp bits), stall counter.
- **Candidate set:**
  - ARB: all `v_i`.
  - LOCKED: only `v_i[owner]`.
- **Grant:** the first set candidate scanning `ptr_r, ptr_r+1, …` modulo els_p. Grant logic is combinational, with no added latency.
- **Presentation:**
  - `v_o = any_candidate & credit_avail_i & ~reset_i`.
  - `tag_o` = grant index.
  - `last_o = last_i[grant]`.
- **Transfer:** `xfer = v_o & ready_i`.
  - `yumi_o[grant] = xfer`; all other `yumi_o` bits are 0.
  - `dec_credit_o = xfer`: exactly one credit per word.
- **Transitions, applied at the posedge after `xfer`:**
  - ARB, `last_o = 0`: go to LOCKED; `owner <= grant`; `ptr_r` is unchanged.
  - ARB, `last_o = 1`: stay in ARB; `ptr_r <= (grant+1) mod els_p`.
  - LOCKED, `last_o = 1`: go to ARB; `ptr_r <= (owner+1) mod els_p`.
  - LOCKED, `last_o = 0`: stay in LOCKED.
  - No `xfer`: state, owner and `ptr_r` hold.
- **Locked owner drops valid:** stay in LOCKED. Other requesters get no grant; their `yumi_o` stays 0. There is no timeout.
- **Stall counter:**
  - Increments when `any_candidate & ready_i & ~credit_avail_i`.
  - Saturates at `2^stall_width_p − 1`; it does not wrap.
  - `stall_clear_i` has priority over an increment in the same cycle.
- **Credit loss mid-packet:** the lock is kept. Transfer resumes when `credit_avail_i` returns. Each stalled cycle is counted.
- **Reset:**
  - State ARB; `owner = 0`; `ptr_r = 0`; `stall_cnt_o = 0`.
  - While `reset_i` is high: `v_o`, `yumi_o` and `dec_credit_o` are 0. `tag_o` and `last_o` are don't-care.
  - Reset during LOCKED abandons the packet; the next grant is arbitrated from `ptr_r = 0`.
- **Pointer wrap:** `ptr_r` wraps from `els_p−1` to 0. For non-power-of-two els_p, the modulo is explicit; the pointer never holds an index ≥ els_p.

## Timing
- Zero-cycle path from `v_i`, `last_i`, `credit_avail_i` and `ready_i` to `v_o`, `yumi_o` and `dec_credit_o`. All inputs must be stable before the clock edge.
- `credit_avail_i` must reflect the `dec_credit_o` of the previous cycle. The credit counter registers its decrement, so a decrement is seen next cycle. Back-to-back transfers are legal while credits remain.
- Throughput: one word per cycle.
- Arbitration fairness: a requester holding `v_i` continuously is granted within `els_p−1` packets.
- State, pointer and counter update only at posedge `clk_i`.

## Test plan
1. **Reset with all inputs asserted:** reset_i=1, v_i=4'b1111, credit_avail_i=1, ready_i=1 → v_o=0, yumi_o=0, dec_credit_o=0. After release: first grant tag_o=0, stall_cnt_o=0.
2. **Round-robin single-word packets:** v_i=4'b1111, last_i=4'b1111, credits and ready high → tag_o sequence 0,1,2,3,0 on consecutive cycles; dec_credit_o=1 on every cycle.
3. **Lock:** req 1 sends a 3-word packet (last on word 3) while req 2 is continuously valid.
   - Required: tag_o=1 for 3 cycles, yumi_o[2]=0 throughout, then tag_o=2.
4. **Credit starvation mid-packet:** credit_avail_i=0 for 5 cycles during a locked packet, with ready_i=1.
   - Required: v_o=0 and dec_credit_o=0 during the 5 cycles; stall_cnt_o rises by 5; the lock and owner are kept; the packet completes afterward.
5. **Stall counter saturate and clear:** stall_width_p=4, hold starvation for 20 cycles → stall_cnt_o=15.
   - stall_clear_i asserted together with an increment condition → stall_cnt_o=0 next cycle.
6. **Reset mid-lock and non-power-of-two wrap:** reset_i pulsed while req 2 holds the lock → state ARB, ptr_r=0.
   - With els_p=3 and all requesters valid → tag_o sequence 0,1,2,0 with no out-of-range tag.

Source files
------------

// File: rtl/bsg_credit_rr_arb.sv
// Credit-gated round-robin arbiter for one credit-flow-controlled channel.
// A multi-word packet locks the grant to its owner; credit-starved cycles are counted.
module bsg_credit_rr_arb #(
    parameter int unsigned els_p         = 4,
    parameter int unsigned stall_width_p = 16,
    localparam int unsigned lg_els_lp    = $clog2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [els_p-1:0]         v_i,
    input  logic [els_p-1:0]         last_i,
    output logic [els_p-1:0]         yumi_o,
    input  logic                     credit_avail_i,
    output logic                     dec_credit_o,
    input  logic                     ready_i,
    output logic                     v_o,
    output logic                     last_o,
    output logic [lg_els_lp-1:0]     tag_o,
    input  logic                     stall_clear_i,
    output logic [stall_width_p-1:0] stall_cnt_o
);

    typedef enum logic {ARB, LOCKED} state_e;

    localparam logic [lg_els_lp-1:0] last_idx_lp = lg_els_lp'(els_p - 1);

    state_e                   state_r, state_n;
    logic [lg_els_lp-1:0]     owner_r, owner_n;
    logic [lg_els_lp-1:0]     ptr_r, ptr_n;
    logic [stall_width_p-1:0] stall_r;

    logic [els_p-1:0]     cand;
    logic [lg_els_lp-1:0] grant;
    logic                 found;
    logic                 any_cand;
    logic                 xfer;
    logic                 stall_inc;
    int unsigned          scan_idx;

    // Explicit wrap keeps the pointer in range for non-power-of-two els_p.
    function automatic logic [lg_els_lp-1:0] wrap_inc(input logic [lg_els_lp-1:0] idx);
        return (idx == last_idx_lp) ? '0 : idx + 1'b1;
    endfunction

    always_comb begin
        cand = v_i;
        if (state_r == LOCKED) begin
            cand = '0;
            cand[owner_r] = v_i[owner_r];
        end
        grant    = '0;
        found    = 1'b0;
        scan_idx = 0;
        for (int unsigned i = 0; i < els_p; i++) begin
            scan_idx = 32'(ptr_r) + i;
            if (scan_idx >= els_p) begin
                scan_idx = scan_idx - els_p;
            end
            if (!found && cand[scan_idx[lg_els_lp-1:0]]) begin
                found = 1'b1;
                grant = scan_idx[lg_els_lp-1:0];
            end
        end
    end

    assign any_cand     = |cand;
    assign v_o          = any_cand & credit_avail_i & ~reset_i;
    assign xfer         = v_o & ready_i;
    assign dec_credit_o = xfer;
    assign tag_o        = grant;
    assign last_o       = last_i[grant];
    assign stall_inc    = any_cand & ready_i & ~credit_avail_i;
    assign stall_cnt_o  = stall_r;

    always_comb begin
        yumi_o        = '0;
        yumi_o[grant] = xfer;
    end

    always_comb begin
        state_n = state_r;
        owner_n = owner_r;
        ptr_n   = ptr_r;
        if (xfer) begin
            unique case (state_r)
                ARB: begin
                    if (last_o) begin
                        ptr_n = wrap_inc(grant);
                    end else begin
                        state_n = LOCKED;
                        owner_n = grant;
                    end
                end
                LOCKED: begin
                    if (last_o) begin
                        state_n = ARB;
                        ptr_n   = wrap_inc(owner_r);
                    end
                end
                default: state_n = ARB;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= ARB;
            owner_r <= '0;
            ptr_r   <= '0;
        end else begin
            state_r <= state_n;
            owner_r <= owner_n;
            ptr_r   <= ptr_n;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || stall_clear_i) begin
            stall_r <= '0;
        end else if (stall_inc && (stall_r != '1)) begin
            stall_r <= stall_r + 1'b1;
        end
    end

endmodule

// File: tb/tb_bsg_credit_rr_arb.sv
// Bench for bsg_credit_rr_arb: a 4-requester/4-bit-stall instance and a 3-requester instance,
// both checked every cycle against a packet-level reference model, plus directed scenarios.
module tb_bsg_credit_rr_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, credit, ready, clr;
    logic [3:0] v0, l0, y0;
    logic [2:0] v1, l1, y1;
    logic vo0, lo0, dec0, vo1, lo1, dec1;
    logic [1:0] tag0, tag1;
    logic [3:0] st0;
    logic [15:0] st1;

    int checks = 0;
    int errors = 0;

    int unsigned n_el[2] = '{4, 3};
    int unsigned smax[2] = '{15, 65535};

    bit          m_locked[2];
    int unsigned m_owner[2], m_ptr[2], m_stall[2];
    int unsigned e_grant[2];
    bit          e_xfer[2], e_any[2], e_last[2];

    bsg_credit_rr_arb #(.els_p(4), .stall_width_p(4)) dut (
        .clk_i(clk), .reset_i(reset), .v_i(v0), .last_i(l0), .yumi_o(y0),
        .credit_avail_i(credit), .dec_credit_o(dec0), .ready_i(ready),
        .v_o(vo0), .last_o(lo0), .tag_o(tag0),
        .stall_clear_i(clr), .stall_cnt_o(st0)
    );

    bsg_credit_rr_arb #(.els_p(3), .stall_width_p(16)) dut3 (
        .clk_i(clk), .reset_i(reset), .v_i(v1), .last_i(l1), .yumi_o(y1),
        .credit_avail_i(credit), .dec_credit_o(dec1), .ready_i(ready),
        .v_o(vo1), .last_o(lo1), .tag_o(tag1),
        .stall_clear_i(clr), .stall_cnt_o(st1)
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
        end
    endtask

    // Let combinational outputs settle, then compare both instances with the model.
    task automatic settle();
        int unsigned vv, ll, cand, n, g;
        bit found, ev;
        logic [31:0] ov, oy, od, ot, ol, os;
        #1;
        for (int d = 0; d < 2; d++) begin
            n  = n_el[d];
            vv = (d == 0) ? 32'(v0) : 32'(v1);
            ll = (d == 0) ? 32'(l0) : 32'(l1);
            cand = m_locked[d] ? (vv & (32'd1 << m_owner[d])) : vv;
            found = 1'b0;
            g = 0;
            for (int unsigned k = 0; k < n; k++) begin
                if (!found && cand[(m_ptr[d] + k) % n]) begin
                    found = 1'b1;
                    g = (m_ptr[d] + k) % n;
                end
            end
            ev = found && credit && !reset;
            e_any[d]   = found;
            e_grant[d] = g;
            e_xfer[d]  = ev && ready;
            e_last[d]  = ll[g];
            ov = (d == 0) ? 32'(vo0)  : 32'(vo1);
            oy = (d == 0) ? 32'(y0)   : 32'(y1);
            od = (d == 0) ? 32'(dec0) : 32'(dec1);
            ot = (d == 0) ? 32'(tag0) : 32'(tag1);
            ol = (d == 0) ? 32'(lo0)  : 32'(lo1);
            os = (d == 0) ? 32'(st0)  : 32'(st1);
            chk($sformatf("d%0d v_o", d), ov, 32'(ev));
            chk($sformatf("d%0d yumi_o", d), oy, e_xfer[d] ? (32'd1 << g) : 32'd0);
            chk($sformatf("d%0d dec_credit_o", d), od, 32'(e_xfer[d]));
            if (ev) begin
                chk($sformatf("d%0d tag_o", d), ot, g);
                chk($sformatf("d%0d last_o", d), ol, 32'(e_last[d]));
            end
            if (!reset) begin
                chk($sformatf("d%0d stall_cnt_o", d), os, m_stall[d]);
            end
        end
    endtask

    // Apply the packet rules to the model, then cross the clock edge.
    task automatic adv();
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                m_locked[d] = 1'b0;
                m_owner[d]  = 0;
                m_ptr[d]    = 0;
                m_stall[d]  = 0;
            end else begin
                if (clr) m_stall[d] = 0;
                else if (e_any[d] && ready && !credit && m_stall[d] < smax[d]) m_stall[d]++;
                if (e_xfer[d]) begin
                    if (!m_locked[d]) begin
                        if (e_last[d]) m_ptr[d] = (e_grant[d] + 1) % n_el[d];
                        else begin
                            m_locked[d] = 1'b1;
                            m_owner[d]  = e_grant[d];
                        end
                    end else if (e_last[d]) begin
                        m_locked[d] = 1'b0;
                        m_ptr[d]    = (m_owner[d] + 1) % n_el[d];
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned seq0[5] = '{0, 1, 2, 3, 0};
        int unsigned seq1[4] = '{0, 1, 2, 0};

        // Reset with every input asserted
        reset = 1'b1; clr = 1'b0; credit = 1'b1; ready = 1'b1;
        v0 = 4'b1111; l0 = 4'b1111; v1 = 3'b111; l1 = 3'b111;
        settle(); adv();
        settle(); adv();
        reset = 1'b0;

        // Round-robin single-word packets; the 3-wide instance wraps 2 -> 0
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("rr tag", 32'(tag0), seq0[i]);
            if (i < 4) chk("rr3 tag", 32'(tag1), seq1[i]);
            adv();
        end
        chk("stall after reset", 32'(st0), 0);

        // Requester 1 sends 3 words while requester 2 stays valid
        v0 = 4'b0110;
        for (int i = 0; i < 3; i++) begin
            l0 = (i == 2) ? 4'b0010 : 4'b0000;
            settle();
            chk("lock tag", 32'(tag0), 1);
            chk("lock yumi2", 32'(y0[2]), 0);
            adv();
        end
        l0 = 4'b0100;
        settle();
        chk("post-lock tag", 32'(tag0), 2);
        adv();

        // Credit starvation in the middle of a locked packet
        clr = 1'b1; v0 = 4'b0000;
        settle(); adv();
        clr = 1'b0; v0 = 4'b1000; l0 = 4'b0000;
        settle(); adv();
        credit = 1'b0; v0 = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("starve v_o", 32'(vo0), 0);
            chk("starve dec", 32'(dec0), 0);
            adv();
        end
        credit = 1'b1; l0 = 4'b1000;
        settle();
        chk("starve count", 32'(st0), 5);
        chk("resume tag", 32'(tag0), 3);
        adv();

        // Saturation of the 4-bit stall counter, then clear against an increment
        credit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            settle(); adv();
        end
        settle();
        chk("stall saturated", 32'(st0), 15);
        clr = 1'b1;
        adv();
        clr = 1'b0;
        settle();
        chk("stall cleared", 32'(st0), 0);
        adv();

        // Reset while requester 2 holds the lock
        credit = 1'b1; v0 = 4'b0100; l0 = 4'b0000;
        settle(); adv();
        reset = 1'b1;
        settle(); adv();
        reset = 1'b0; v0 = 4'b1111; l0 = 4'b1111;
        settle();
        chk("post-reset tag", 32'(tag0), 0);
        adv();

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            reset  = ($urandom_range(0, 63) == 0);
            clr    = ($urandom_range(0, 31) == 0);
            credit = ($urandom_range(0, 9) < 8);
            ready  = ($urandom_range(0, 3) != 0);
            v0 = 4'($urandom);
            l0 = 4'($urandom);
            v1 = 3'($urandom);
            l1 = 3'($urandom);
            settle(); adv();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
